// File: rtl/menu_pkg.sv
// Shared types and constants for the menu status overlay.
// Provides 5-bit character codes understood by the 7-segment character
// decoder, the overlay FSM state type and select-field identifiers.
package menu_pkg;

    typedef logic [4:0] char_t;

    typedef enum logic {
        PASS,
        SHOW
    } overlay_state_t;

    // Non-hex glyphs; 0x00-0x0F are the hex digits themselves
    localparam char_t CH_BLANK = 5'h10;
    localparam char_t CH_DASH  = 5'h11;
    localparam char_t CH_N     = 5'h12;
    localparam char_t CH_I     = 5'h13;
    localparam char_t CH_H     = 5'h14;

    // Hex glyphs reused as letters inside labels
    localparam char_t CH_5 = 5'h05;
    localparam char_t CH_A = 5'h0A;
    localparam char_t CH_B = 5'h0B;
    localparam char_t CH_C = 5'h0C;
    localparam char_t CH_D = 5'h0D;

    // Select-field identifiers, in descending display priority
    localparam logic [1:0] FLD_ADC   = 2'd0;
    localparam logic [1:0] FLD_MODE  = 2'd1;
    localparam logic [1:0] FLD_SCALE = 2'd2;
    localparam logic [1:0] FLD_HB    = 2'd3;

endpackage : menu_pkg

// File: rtl/menu_label_rom.sv
// Combinational label lookup for the status overlay.
// Ports:
//   field_id  - which select changed (FLD_* from menu_pkg)
//   field_val - new value of that select
//   label     - four character codes, label[3] is the leftmost digit
module menu_label_rom
    import menu_pkg::*;
(
    input  logic [1:0]  field_id,
    input  logic [1:0]  field_val,
    output char_t [3:0] label
);

    // Last digit always shows the new value as a hex glyph
    char_t val_char;
    assign val_char = char_t'({3'b000, field_val});

    always_comb begin
        label = {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
        case (field_id)
            FLD_ADC:   label = {CH_A, CH_D, CH_DASH, val_char};
            FLD_MODE:  label = {CH_I, CH_N, CH_DASH, val_char};
            FLD_SCALE: label = {CH_5, CH_C, CH_DASH, val_char};
            FLD_HB:    label = {CH_H, CH_B, CH_DASH, val_char};
            default:   label = {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
        endcase
    end

endmodule : menu_label_rom

// File: rtl/menu_status_overlay.sv
// Overlays a short setting label on the 4-digit 7-segment path whenever a
// menu select changes, holds it for HOLD_CYCLES clocks, then returns to
// live pass-through.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   adc_sel, mode_sel,
//   scale_sel,
//   hex_BCD_sel         - menu select buses (clk domain)
//   data_digits/data_dp - live nibbles and decimal points, [MSB] leftmost
//   disp_chars/disp_dp  - registered character codes and dps to decoder
//   overlay_active      - registered, high while a label is displayed
module menu_status_overlay
    import menu_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 150_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  adc_sel,
    input  logic [1:0]  mode_sel,
    input  logic [1:0]  scale_sel,
    input  logic        hex_BCD_sel,
    input  logic [15:0] data_digits,
    input  logic [3:0]  data_dp,
    output logic [19:0] disp_chars,
    output logic [3:0]  disp_dp,
    output logic        overlay_active
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    overlay_state_t   state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    char_t [3:0]      label_q, label_d;
    logic [1:0]       prev_adc, prev_mode, prev_scale;
    logic             prev_hb;

    logic [19:0]      disp_chars_d;
    logic [3:0]       disp_dp_d;
    logic             overlay_active_d;

    logic             chg_adc, chg_mode, chg_scale, chg_hb, any_chg;
    logic [1:0]       win_id, win_val;
    char_t [3:0]      rom_label;
    char_t [3:0]      live_chars;

    // Change detection against last-cycle samples
    assign chg_adc   = (adc_sel != prev_adc);
    assign chg_mode  = (mode_sel != prev_mode);
    assign chg_scale = (scale_sel != prev_scale);
    assign chg_hb    = (hex_BCD_sel != prev_hb);
    assign any_chg   = chg_adc | chg_mode | chg_scale | chg_hb;

    // Priority encoder: adc > mode > scale > hex_BCD
    always_comb begin
        win_id  = FLD_HB;
        win_val = {1'b0, hex_BCD_sel};
        if (chg_adc) begin
            win_id  = FLD_ADC;
            win_val = adc_sel;
        end else if (chg_mode) begin
            win_id  = FLD_MODE;
            win_val = mode_sel;
        end else if (chg_scale) begin
            win_id  = FLD_SCALE;
            win_val = scale_sel;
        end
    end

    menu_label_rom u_label_rom (
        .field_id  (win_id),
        .field_val (win_val),
        .label     (rom_label)
    );

    // Live nibbles become hex glyph codes
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            live_chars[i] = char_t'({1'b0, data_digits[i*4 +: 4]});
        end
    end

    // Next-state, hold counter and next-output logic
    always_comb begin
        state_d          = state_q;
        hold_cnt_d       = hold_cnt_q;
        label_d          = label_q;
        disp_chars_d     = live_chars;
        disp_dp_d        = data_dp;
        overlay_active_d = 1'b0;

        case (state_q)
            PASS: begin
                if (any_chg) begin
                    state_d    = SHOW;
                    hold_cnt_d = HOLD_LOAD;
                    label_d    = rom_label;
                end
            end
            SHOW: begin
                if (any_chg) begin
                    hold_cnt_d = HOLD_LOAD;
                    label_d    = rom_label;
                end else if (hold_cnt_q == '0) begin
                    state_d = PASS;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = PASS;
        endcase

        if (state_d == SHOW) begin
            disp_chars_d     = label_d;
            disp_dp_d        = 4'b0000;
            overlay_active_d = 1'b1;
        end
    end

    // State, counter, select history and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= PASS;
            hold_cnt_q     <= '0;
            label_q        <= {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
            prev_adc       <= adc_sel;
            prev_mode      <= mode_sel;
            prev_scale     <= scale_sel;
            prev_hb        <= hex_BCD_sel;
            disp_chars     <= {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
            disp_dp        <= 4'b0000;
            overlay_active <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            label_q        <= label_d;
            prev_adc       <= adc_sel;
            prev_mode      <= mode_sel;
            prev_scale     <= scale_sel;
            prev_hb        <= hex_BCD_sel;
            disp_chars     <= disp_chars_d;
            disp_dp        <= disp_dp_d;
            overlay_active <= overlay_active_d;
        end
    end

endmodule : menu_status_overlay

// File: tb/tb_menu_status_overlay.sv
// Bench for menu_status_overlay with HOLD_CYCLES = 8: a timestamp-based
// model checked every cycle, plus hand-computed literal checkpoints.
module tb_menu_status_overlay;

    localparam int unsigned HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  adc_sel, mode_sel, scale_sel;
    logic        hex_BCD_sel;
    logic [15:0] data_digits;
    logic [3:0]  data_dp;
    logic [19:0] disp_chars;
    logic [3:0]  disp_dp;
    logic        overlay_active;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    menu_status_overlay #(.HOLD_CYCLES(HOLD)) dut (
        .clk            (clk),
        .reset          (reset),
        .adc_sel        (adc_sel),
        .mode_sel       (mode_sel),
        .scale_sel      (scale_sel),
        .hex_BCD_sel    (hex_BCD_sel),
        .data_digits    (data_digits),
        .data_dp        (data_dp),
        .disp_chars     (disp_chars),
        .disp_dp        (disp_dp),
        .overlay_active (overlay_active)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The label is on screen while fewer than HOLD edges have passed since
    // the most recent change; the label is that of the most recent change.
    int          cyc = 0;
    int          last_chg = -1000;
    logic [19:0] m_label;
    logic [1:0]  m_adc, m_mode, m_scale;
    logic        m_hb;
    logic [19:0] exp_chars;
    logic [3:0]  exp_dp;
    logic        exp_act;

    function automatic logic [19:0] label_of(input int fld, input logic [1:0] v);
        logic [4:0] x;
        x = {3'b000, v};
        case (fld)
            0:       return {5'h0A, 5'h0D, 5'h11, x};
            1:       return {5'h13, 5'h12, 5'h11, x};
            2:       return {5'h05, 5'h0C, 5'h11, x};
            default: return {5'h14, 5'h0B, 5'h11, x};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            last_chg  = -1000;
            exp_chars = {4{5'h10}};
            exp_dp    = 4'b0000;
            exp_act   = 1'b0;
        end else begin
            if (adc_sel != m_adc) begin
                last_chg = cyc; m_label = label_of(0, adc_sel);
            end else if (mode_sel != m_mode) begin
                last_chg = cyc; m_label = label_of(1, mode_sel);
            end else if (scale_sel != m_scale) begin
                last_chg = cyc; m_label = label_of(2, scale_sel);
            end else if (hex_BCD_sel != m_hb) begin
                last_chg = cyc; m_label = label_of(3, {1'b0, hex_BCD_sel});
            end
            if (cyc - last_chg < int'(HOLD)) begin
                exp_chars = m_label;
                exp_dp    = 4'b0000;
                exp_act   = 1'b1;
            end else begin
                exp_chars = {1'b0, data_digits[15:12], 1'b0, data_digits[11:8],
                             1'b0, data_digits[7:4],   1'b0, data_digits[3:0]};
                exp_dp    = data_dp;
                exp_act   = 1'b0;
            end
        end
        m_adc   = adc_sel;
        m_mode  = mode_sel;
        m_scale = scale_sel;
        m_hb    = hex_BCD_sel;
        cyc++;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (disp_chars !== exp_chars || disp_dp !== exp_dp || overlay_active !== exp_act) begin
                n_err++;
                $display("FAIL model t=%0t chars=%05h/%05h dp=%b/%b act=%b/%b (got/exp)",
                         $time, disp_chars, exp_chars, disp_dp, exp_dp, overlay_active, exp_act);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%05h exp=%05h", name, got, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        adc_sel     = 2'd2;
        mode_sel    = 2'd0;
        scale_sel   = 2'd0;
        hex_BCD_sel = 1'b0;
        data_digits = 16'h1234;
        data_dp     = 4'b0000;

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        tick(2);
        check("reset_chars", disp_chars, {4{5'h10}});
        check("reset_act", 20'(overlay_active), 20'd0);

        // Release: pass-through of 0x1234, no overlay from adc_sel = 2
        reset = 1'b0;
        tick();
        check("post_reset_chars", disp_chars, {5'h01, 5'h02, 5'h03, 5'h04});
        check("post_reset_act", 20'(overlay_active), 20'd0);
        tick(3);

        // Prepare adc_sel = 0, let that label expire
        adc_sel = 2'd0;
        tick(10);

        // adc 0 -> 1: "Ad-1" for exactly 8 edges
        adc_sel = 2'd1;
        tick();
        check("adc_label", disp_chars, {5'h0A, 5'h0D, 5'h11, 5'h01});
        check("adc_act_first", 20'(overlay_active), 20'd1);
        tick(7);
        check("adc_act_last", 20'(overlay_active), 20'd1);
        data_digits = 16'hBEEF;
        tick();
        check("adc_act_end", 20'(overlay_active), 20'd0);
        check("adc_pass_chars", disp_chars, {5'h0B, 5'h0E, 5'h0E, 5'h0F});
        tick(3);

        // Simultaneous scale and mode changes: mode wins
        scale_sel = 2'd3;
        mode_sel  = 2'd2;
        tick();
        check("mode_wins", disp_chars, {5'h13, 5'h12, 5'h11, 5'h02});
        tick(10);

        // Retrigger with 3 cycles left
        adc_sel = 2'd2;
        tick(5);
        hex_BCD_sel = 1'b1;
        tick();
        check("hb_label", disp_chars, {5'h14, 5'h0B, 5'h11, 5'h01});
        tick(7);
        check("hb_act_last", 20'(overlay_active), 20'd1);
        tick();
        check("hb_act_end", 20'(overlay_active), 20'd0);
        tick(2);

        // Decimal points suppressed during the label
        data_dp  = 4'b0100;
        mode_sel = 2'd1;
        tick();
        check("dp_show", 20'(disp_dp), 20'd0);
        tick(8);
        check("dp_pass", 20'(disp_dp), 20'b0100);
        tick(2);

        // Reset two cycles into SHOW aborts the label
        scale_sel = 2'd2;
        tick(2);
        reset = 1'b1;
        tick();
        check("abort_chars", disp_chars, {4{5'h10}});
        check("abort_act", 20'(overlay_active), 20'd0);
        adc_sel = 2'd3;
        tick();
        reset = 1'b0;
        data_digits = 16'h0A5C;
        tick();
        check("abort_no_label", 20'(overlay_active), 20'd0);
        check("abort_pass_chars", disp_chars, {5'h00, 5'h0A, 5'h05, 5'h0C});
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_menu_status_overlay
